// File: rtl/tx_fire_controller.sv
// tx_fire_controller: multi-channel transducer fire sequencer.
// A FIRE command sampled in IDLE latches the per-channel configuration and starts
// a shot. Each channel waits its delay, then emits P pulses of CT cycles. In
// parallel, an ADC trigger request is raised and closed by an ack or a timeout.
module tx_fire_controller #(
    parameter int N_CH    = 4,
    parameter int CT_W    = 9,
    parameter int DLY_W   = 14,
    parameter int DLY_DIV = 1,
    parameter int PER_W   = 16,
    parameter int ACK_TO  = 1023
) (
    input  logic                    txCLK,
    input  logic                    txRSTn,
    input  logic [7:0]              itxControlComms,
    input  logic [N_CH*CT_W-1:0]    iChargeTime,
    input  logic [N_CH*DLY_W-1:0]   iFireDelay,
    input  logic [N_CH-1:0]         iChanEnable,
    input  logic [7:0]              iPulseCount,
    input  logic [PER_W-1:0]        iPulsePeriod,
    input  logic                    itxADCTriggerAck,
    output logic                    otxADCTriggerLine,
    output logic [N_CH-1:0]         otxTransducerOutput,
    output logic                    otxBusy,
    output logic                    otxDone,
    output logic                    otxAckTimeout
);

    // One counter per channel serves delay, high time and inter-pulse gap,
    // so it is sized for the widest of the three.
    localparam int DCW   = DLY_W + DLY_DIV;
    localparam int GPW   = ((PER_W > CT_W) ? PER_W : CT_W) + 1;
    localparam int CNT_W = (DCW > GPW) ? DCW : GPW;
    localparam int AW    = $clog2(ACK_TO + 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TO - 1);
    localparam logic [7:0]    CMD_FIRE = 8'h01;

    typedef enum logic [1:0] {
        TOP_IDLE = 2'd0,
        TOP_RUN  = 2'd1,
        TOP_DONE = 2'd2
    } top_state_e;

    typedef enum logic [2:0] {
        CH_IDLE = 3'd0,
        CH_WAIT = 3'd1,
        CH_HIGH = 3'd2,
        CH_LOW  = 3'd3,
        CH_FIN  = 3'd4
    } ch_state_e;

    // Low-gap length after a pulse: spacing is max(period, ct+1) rise-to-rise,
    // the pulse itself occupies ct cycles and the rising edge one more.
    function automatic logic [CNT_W-1:0] gap_len(input logic [PER_W-1:0] per,
                                                 input logic [CT_W-1:0]  ct);
        logic [CNT_W-1:0] per_x;
        logic [CNT_W-1:0] ct1_x;
        per_x = CNT_W'(per);
        ct1_x = CNT_W'(ct) + CNT_W'(1);
        if (per_x > ct1_x) begin
            gap_len = per_x - ct1_x;
        end else begin
            gap_len = {CNT_W{1'b0}};
        end
    endfunction

    top_state_e        top_q, top_d;
    ch_state_e         ch_st_q   [N_CH];
    ch_state_e         ch_st_d   [N_CH];
    logic [CNT_W-1:0]  ch_cnt_q  [N_CH];
    logic [CNT_W-1:0]  ch_cnt_d  [N_CH];
    logic [CT_W-1:0]   ch_ct_q   [N_CH];
    logic [CT_W-1:0]   ch_ct_d   [N_CH];
    logic [7:0]        ch_left_q [N_CH];
    logic [7:0]        ch_left_d [N_CH];
    logic [PER_W-1:0]  per_q, per_d;
    logic [AW-1:0]     ack_cnt_q, ack_cnt_d;
    logic              line_q, line_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic [N_CH-1:0]   out_q, out_d;
    logic              fire_s;
    logic              all_fin_s;

    assign fire_s = (itxControlComms == CMD_FIRE);

    // Next-state logic for the shot FSM, the ADC handshake and every channel FSM.
    always_comb begin
        top_d     = top_q;
        line_d    = line_q;
        busy_d    = busy_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        ack_cnt_d = ack_cnt_q;
        per_d     = per_q;
        all_fin_s = 1'b1;
        for (int c = 0; c < N_CH; c++) begin
            ch_st_d[c]   = ch_st_q[c];
            ch_cnt_d[c]  = ch_cnt_q[c];
            ch_ct_d[c]   = ch_ct_q[c];
            ch_left_d[c] = ch_left_q[c];
            all_fin_s    = all_fin_s & (ch_st_q[c] == CH_FIN);
        end

        case (top_q)
            TOP_IDLE: begin
                if (fire_s) begin
                    top_d     = TOP_RUN;
                    line_d    = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    tmo_d     = 1'b0;
                    ack_cnt_d = {AW{1'b0}};
                    per_d     = iPulsePeriod;
                    for (int c = 0; c < N_CH; c++) begin
                        ch_ct_d[c]   = iChargeTime[c*CT_W +: CT_W];
                        ch_left_d[c] = (iPulseCount == 8'd0) ? 8'd1 : iPulseCount;
                        if (!iChanEnable[c] || (iChargeTime[c*CT_W +: CT_W] == {CT_W{1'b0}})) begin
                            ch_st_d[c]  = CH_FIN;
                            ch_cnt_d[c] = {CNT_W{1'b0}};
                        end else begin
                            ch_st_d[c]  = CH_WAIT;
                            ch_cnt_d[c] = CNT_W'(iFireDelay[c*DLY_W +: DLY_W]) << DLY_DIV;
                        end
                    end
                end else begin
                    top_d = TOP_IDLE;
                end
            end

            TOP_RUN: begin
                if (!fire_s) begin
                    // Abort: everything drops at this edge; the timeout flag survives.
                    top_d     = TOP_IDLE;
                    line_d    = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b0;
                    ack_cnt_d = {AW{1'b0}};
                    for (int c = 0; c < N_CH; c++) begin
                        ch_st_d[c]   = CH_IDLE;
                        ch_cnt_d[c]  = {CNT_W{1'b0}};
                        ch_left_d[c] = 8'd0;
                    end
                end else begin
                    if (all_fin_s && !line_q) begin
                        top_d  = TOP_DONE;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        top_d = TOP_RUN;
                    end

                    if (line_q) begin
                        if (itxADCTriggerAck) begin
                            line_d = 1'b0;
                        end else if (ack_cnt_q == ACK_LAST) begin
                            line_d = 1'b0;
                            tmo_d  = 1'b1;
                        end else begin
                            ack_cnt_d = ack_cnt_q + AW'(1);
                        end
                    end else begin
                        line_d = 1'b0;
                    end

                    for (int c = 0; c < N_CH; c++) begin
                        case (ch_st_q[c])
                            CH_WAIT, CH_LOW: begin
                                if (ch_cnt_q[c] == {CNT_W{1'b0}}) begin
                                    ch_st_d[c]  = CH_HIGH;
                                    ch_cnt_d[c] = CNT_W'(ch_ct_q[c]) - CNT_W'(1);
                                end else begin
                                    ch_cnt_d[c] = ch_cnt_q[c] - CNT_W'(1);
                                end
                            end
                            CH_HIGH: begin
                                if (ch_cnt_q[c] != {CNT_W{1'b0}}) begin
                                    ch_cnt_d[c] = ch_cnt_q[c] - CNT_W'(1);
                                end else if (ch_left_q[c] <= 8'd1) begin
                                    ch_st_d[c]   = CH_FIN;
                                    ch_left_d[c] = 8'd0;
                                end else begin
                                    ch_st_d[c]   = CH_LOW;
                                    ch_cnt_d[c]  = gap_len(per_q, ch_ct_q[c]);
                                    ch_left_d[c] = ch_left_q[c] - 8'd1;
                                end
                            end
                            default: begin
                                ch_st_d[c] = ch_st_q[c];
                            end
                        endcase
                    end
                end
            end

            TOP_DONE: begin
                if (!fire_s) begin
                    top_d  = TOP_IDLE;
                    done_d = 1'b0;
                    for (int c = 0; c < N_CH; c++) begin
                        ch_st_d[c]  = CH_IDLE;
                        ch_cnt_d[c] = {CNT_W{1'b0}};
                    end
                end else begin
                    top_d = TOP_DONE;
                end
            end

            default: begin
                top_d  = TOP_IDLE;
                line_d = 1'b0;
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase

        for (int c = 0; c < N_CH; c++) begin
            out_d[c] = (ch_st_d[c] == CH_HIGH);
        end
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge txCLK or negedge txRSTn) begin
        if (!txRSTn) begin
            top_q     <= TOP_IDLE;
            per_q     <= {PER_W{1'b0}};
            ack_cnt_q <= {AW{1'b0}};
            line_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            out_q     <= {N_CH{1'b0}};
            for (int c = 0; c < N_CH; c++) begin
                ch_st_q[c]   <= CH_IDLE;
                ch_cnt_q[c]  <= {CNT_W{1'b0}};
                ch_ct_q[c]   <= {CT_W{1'b0}};
                ch_left_q[c] <= 8'd0;
            end
        end else begin
            top_q     <= top_d;
            per_q     <= per_d;
            ack_cnt_q <= ack_cnt_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            out_q     <= out_d;
            for (int c = 0; c < N_CH; c++) begin
                ch_st_q[c]   <= ch_st_d[c];
                ch_cnt_q[c]  <= ch_cnt_d[c];
                ch_ct_q[c]   <= ch_ct_d[c];
                ch_left_q[c] <= ch_left_d[c];
            end
        end
    end

    assign otxADCTriggerLine   = line_q;
    assign otxTransducerOutput = out_q;
    assign otxBusy             = busy_q;
    assign otxDone             = done_q;
    assign otxAckTimeout       = tmo_q;

endmodule

// File: tb/tb_tx_fire_controller.sv
// Testbench for tx_fire_controller: directed shots with literal expectations
// plus randomized shots, all checked every cycle against a shot-level model.
`timescale 1ns/1ps
module tb_tx_fire_controller;

    localparam int N_CH    = 4;
    localparam int CT_W    = 9;
    localparam int DLY_W   = 14;
    localparam int DLY_DIV = 1;
    localparam int PER_W   = 16;
    localparam int ACK_TO  = 1023;
    localparam int TICK    = 1 << DLY_DIV;
    localparam int REC_N   = 2048;

    logic                  txCLK = 1'b0;
    logic                  txRSTn = 1'b0;
    logic [7:0]            itxControlComms = 8'h00;
    logic [N_CH*CT_W-1:0]  iChargeTime = '0;
    logic [N_CH*DLY_W-1:0] iFireDelay = '0;
    logic [N_CH-1:0]       iChanEnable = '0;
    logic [7:0]            iPulseCount = 8'd0;
    logic [PER_W-1:0]      iPulsePeriod = '0;
    logic                  itxADCTriggerAck = 1'b0;
    logic                  otxADCTriggerLine;
    logic [N_CH-1:0]       otxTransducerOutput;
    logic                  otxBusy;
    logic                  otxDone;
    logic                  otxAckTimeout;

    tx_fire_controller #(
        .N_CH(N_CH), .CT_W(CT_W), .DLY_W(DLY_W), .DLY_DIV(DLY_DIV),
        .PER_W(PER_W), .ACK_TO(ACK_TO)
    ) dut (
        .txCLK(txCLK), .txRSTn(txRSTn), .itxControlComms(itxControlComms),
        .iChargeTime(iChargeTime), .iFireDelay(iFireDelay), .iChanEnable(iChanEnable),
        .iPulseCount(iPulseCount), .iPulsePeriod(iPulsePeriod),
        .itxADCTriggerAck(itxADCTriggerAck), .otxADCTriggerLine(otxADCTriggerLine),
        .otxTransducerOutput(otxTransducerOutput), .otxBusy(otxBusy),
        .otxDone(otxDone), .otxAckTimeout(otxAckTimeout)
    );

    always #5 txCLK = ~txCLK;

    int errors = 0;
    int checks = 0;

    // Shot-level model: mode 0 idle, 1 running, 2 done; t counts edges since FIRE.
    int m_mode = 0;
    int m_t = 0;
    int m_en [N_CH];
    int m_ct [N_CH];
    int m_d  [N_CH];
    int m_p = 1;
    int m_per = 0;
    int m_ack_res = -1;
    int m_tmo = 0;
    int m_fin_all = 0;

    int cfg_ct [N_CH];
    int cfg_d  [N_CH];

    logic [N_CH-1:0] rec_trans [REC_N];
    logic            rec_line  [REC_N];
    logic            rec_done  [REC_N];
    logic            rec_tmo   [REC_N];

    function automatic int spacing(input int c);
        return (m_per > m_ct[c] + 1) ? m_per : m_ct[c] + 1;
    endfunction

    function automatic bit ch_high(input int c, input int t);
        int u;
        if (m_en[c] == 0 || m_ct[c] == 0) return 1'b0;
        u = t - 1 - m_d[c] * TICK;
        if (u < 0) return 1'b0;
        return ((u / spacing(c)) < m_p) && ((u % spacing(c)) < m_ct[c]);
    endfunction

    function automatic int ch_fin(input int c);
        if (m_en[c] == 0 || m_ct[c] == 0) return 0;
        return 1 + m_d[c] * TICK + (m_p - 1) * spacing(c) + m_ct[c];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", name, m_t, act, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        int mx;
        if (!txRSTn) begin
            m_mode = 0; m_tmo = 0; m_t = 0;
            return;
        end
        case (m_mode)
            0: begin
                if (itxControlComms == 8'h01) begin
                    for (int c = 0; c < N_CH; c++) begin
                        m_en[c] = int'(iChanEnable[c]);
                        m_ct[c] = int'(iChargeTime[c*CT_W +: CT_W]);
                        m_d[c]  = int'(iFireDelay[c*DLY_W +: DLY_W]);
                    end
                    m_p = (iPulseCount == 8'd0) ? 1 : int'(iPulseCount);
                    m_per = int'(iPulsePeriod);
                    m_fin_all = 0;
                    for (int c = 0; c < N_CH; c++)
                        if (ch_fin(c) > m_fin_all) m_fin_all = ch_fin(c);
                    m_mode = 1; m_t = 0; m_tmo = 0; m_ack_res = -1;
                end
            end
            1: begin
                m_t++;
                if (itxControlComms != 8'h01) begin
                    m_mode = 0;
                end else begin
                    if (m_ack_res < 0) begin
                        if (itxADCTriggerAck) m_ack_res = m_t;
                        else if (m_t == ACK_TO) begin m_ack_res = m_t; m_tmo = 1; end
                    end
                    mx = (m_fin_all > m_ack_res) ? m_fin_all : m_ack_res;
                    if (m_ack_res >= 0 && m_t >= mx + 1) m_mode = 2;
                end
            end
            default: begin
                m_t++;
                if (itxControlComms != 8'h01) m_mode = 0;
            end
        endcase
    endtask

    task automatic compare();
        logic [N_CH-1:0] et;
        et = '0;
        if (m_mode == 1)
            for (int c = 0; c < N_CH; c++) et[c] = ch_high(c, m_t);
        chk("trans", 32'(otxTransducerOutput), 32'(et));
        chk("line", 32'(otxADCTriggerLine), 32'(m_mode == 1 && m_ack_res < 0));
        chk("busy", 32'(otxBusy), 32'(m_mode == 1));
        chk("done", 32'(otxDone), 32'(m_mode == 2));
        chk("tmo", 32'(otxAckTimeout), 32'(m_tmo != 0));
        if (m_mode != 0 && m_t < REC_N) begin
            rec_trans[m_t] = otxTransducerOutput;
            rec_line[m_t]  = otxADCTriggerLine;
            rec_done[m_t]  = otxDone;
            rec_tmo[m_t]   = otxAckTimeout;
        end
    endtask

    task automatic tick();
        @(posedge txCLK);
        model_edge();
        @(negedge txCLK);
        compare();
    endtask

    task automatic apply_cfg(input logic [N_CH-1:0] en, input int p, input int per);
        for (int c = 0; c < N_CH; c++) begin
            iChargeTime[c*CT_W +: CT_W] = CT_W'(cfg_ct[c]);
            iFireDelay[c*DLY_W +: DLY_W] = DLY_W'(cfg_d[c]);
        end
        iChanEnable = en;
        iPulseCount = 8'(p);
        iPulsePeriod = PER_W'(per);
    endtask

    task automatic scramble_cfg();
        iChargeTime = {$urandom, $urandom};
        iFireDelay = {$urandom, $urandom};
        iChanEnable = 4'($urandom);
        iPulseCount = 8'($urandom);
        iPulsePeriod = 16'($urandom);
    endtask

    // One shot: FIRE until DONE has been held hold_done cycles (or abort/reset).
    task automatic run_shot(input int ack_at, input int hold_done, input int abort_at,
                            input int rst_at, input int chg_at);
        int n;
        int done_seen;
        int nt;
        bit fin;
        for (int i = 0; i < REC_N; i++) begin
            rec_trans[i] = 'x; rec_line[i] = 1'bx; rec_done[i] = 1'bx; rec_tmo[i] = 1'bx;
        end
        itxControlComms = 8'h01;
        n = 0; done_seen = 0; fin = 1'b0;
        while (!fin) begin
            nt = (m_mode == 0) ? 0 : m_t + 1;
            itxADCTriggerAck = (nt == ack_at);
            if (nt == abort_at) itxControlComms = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hA5;
            if (nt == chg_at) scramble_cfg();
            if (rst_at >= 0 && nt == rst_at + 1) begin
                @(posedge txCLK);
                model_edge();
                #2 txRSTn = 1'b0;
                #1;
                m_mode = 0; m_tmo = 0;
                chk("rst_async_trans", 32'(otxTransducerOutput), 32'h0);
                chk("rst_async_busy", 32'(otxBusy), 32'h0);
                @(negedge txCLK);
                compare();
                itxControlComms = 8'h00;
                tick();
                txRSTn = 1'b1;
                fin = 1'b1;
            end else begin
                tick();
                n++;
                if (m_mode == 0) fin = 1'b1;
                else if (m_mode == 2) begin
                    if (done_seen >= hold_done) fin = 1'b1;
                    done_seen++;
                end
                if (n > 6000) begin
                    checks++; errors++;
                    $display("FAIL shot_bound actual=%0d cycles required<=6000", n);
                    fin = 1'b1;
                end
            end
        end
        itxControlComms = 8'h00;
        itxADCTriggerAck = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int r;
        logic [N_CH-1:0] en;
        bit big;
        for (int c = 0; c < N_CH; c++) begin
            m_en[c] = 0; m_ct[c] = 0; m_d[c] = 0; cfg_ct[c] = 0; cfg_d[c] = 0;
        end

        // Reset state
        repeat (3) tick();
        chk("reset_trans", 32'(otxTransducerOutput), 32'h0);
        chk("reset_busy", 32'(otxBusy), 32'h0);
        chk("reset_line", 32'(otxADCTriggerLine), 32'h0);
        txRSTn = 1'b1;
        tick();

        // All channels, D=0, CT=5, P=1, ack at N+3
        for (int c = 0; c < N_CH; c++) begin cfg_ct[c] = 5; cfg_d[c] = 0; end
        apply_cfg(4'hF, 1, 0);
        run_shot(3, 2, -1, -1, -1);
        chk("b38_t1", 32'(rec_trans[1]), 32'hF);
        chk("b38_t5", 32'(rec_trans[5]), 32'hF);
        chk("b38_t6", 32'(rec_trans[6]), 32'h0);
        chk("b38_line2", 32'(rec_line[2]), 32'h1);
        chk("b38_line3", 32'(rec_line[3]), 32'h0);
        chk("b38_done6", 32'(rec_done[6]), 32'h0);
        chk("b38_done7", 32'(rec_done[7]), 32'h1);

        // Staggered delays D={0,1,2,3}, CT=4
        for (int c = 0; c < N_CH; c++) begin cfg_ct[c] = 4; cfg_d[c] = c; end
        apply_cfg(4'hF, 1, 0);
        run_shot(1, 1, -1, -1, -1);
        chk("b39_t1", 32'(rec_trans[1]), 32'h1);
        chk("b39_t3", 32'(rec_trans[3]), 32'h3);
        chk("b39_t5", 32'(rec_trans[5]), 32'h6);
        chk("b39_t7", 32'(rec_trans[7]), 32'hC);
        chk("b39_t11", 32'(rec_trans[11]), 32'h0);

        // Pulse train CT=3, P=3, period 10 then period 2
        for (int c = 0; c < N_CH; c++) begin cfg_ct[c] = 3; cfg_d[c] = 0; end
        apply_cfg(4'h1, 3, 10);
        run_shot(2, 1, -1, -1, -1);
        chk("b40_t10", 32'(rec_trans[10]), 32'h0);
        chk("b40_t11", 32'(rec_trans[11]), 32'h1);
        chk("b40_t21", 32'(rec_trans[21]), 32'h1);
        chk("b40_t24", 32'(rec_trans[24]), 32'h0);
        apply_cfg(4'h1, 3, 2);
        run_shot(2, 1, -1, -1, -1);
        chk("b40_p2_t4", 32'(rec_trans[4]), 32'h0);
        chk("b40_p2_t5", 32'(rec_trans[5]), 32'h1);
        chk("b40_p2_t9", 32'(rec_trans[9]), 32'h1);

        // Ack never arrives: timeout at N+1023
        for (int c = 0; c < N_CH; c++) begin cfg_ct[c] = 5; cfg_d[c] = 0; end
        apply_cfg(4'hF, 1, 0);
        run_shot(-1, 2, -1, -1, -1);
        chk("b41_line1022", 32'(rec_line[1022]), 32'h1);
        chk("b41_line1023", 32'(rec_line[1023]), 32'h0);
        chk("b41_tmo1022", 32'(rec_tmo[1022]), 32'h0);
        chk("b41_tmo1023", 32'(rec_tmo[1023]), 32'h1);
        chk("b41_done1024", 32'(rec_done[1024]), 32'h1);

        // Abort mid-pulse, then async reset mid-pulse, then a fresh shot
        for (int c = 0; c < N_CH; c++) begin cfg_ct[c] = 8; cfg_d[c] = 0; end
        apply_cfg(4'hF, 1, 0);
        run_shot(2, 1, 4, -1, -1);
        chk("b42_pre_abort", 32'(rec_trans[3]), 32'hF);
        apply_cfg(4'hF, 1, 0);
        run_shot(2, 1, -1, 3, -1);
        for (int c = 0; c < N_CH; c++) begin cfg_ct[c] = 5; cfg_d[c] = 0; end
        apply_cfg(4'hF, 1, 0);
        run_shot(3, 1, -1, -1, -1);
        chk("b42_fresh_t1", 32'(rec_trans[1]), 32'hF);
        chk("b42_fresh_t6", 32'(rec_trans[6]), 32'h0);

        // Mask 0101 with CT_2=0; config scrambled at N+2
        cfg_ct[0] = 4; cfg_ct[1] = 6; cfg_ct[2] = 0; cfg_ct[3] = 6;
        for (int c = 0; c < N_CH; c++) cfg_d[c] = 0;
        apply_cfg(4'b0101, 1, 0);
        run_shot(1, 1, -1, -1, 2);
        chk("b43_t1", 32'(rec_trans[1]), 32'h1);
        chk("b43_t4", 32'(rec_trans[4]), 32'h1);
        chk("b43_t5", 32'(rec_trans[5]), 32'h0);

        // Randomized shots
        for (int s = 0; s < 25; s++) begin
            big = 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r = $urandom_range(0, 15);
                cfg_ct[c] = (r == 15) ? 511 : $urandom_range(0, 10);
                if (r == 15) big = 1'b1;
                cfg_d[c] = $urandom_range(0, 20);
            end
            en = 4'($urandom_range(0, 15));
            apply_cfg(en, big ? $urandom_range(0, 2) : $urandom_range(0, 4), $urandom_range(0, 25));
            r = $urandom_range(0, 9);
            run_shot((r == 0) ? -1 : (r == 1) ? 0 : $urandom_range(1, 40),
                     $urandom_range(0, 4),
                     ($urandom_range(0, 4) == 0) ? $urandom_range(1, 30) : -1,
                     -1,
                     $urandom_range(1, 10));
            repeat ($urandom_range(0, 2)) begin
                itxControlComms = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'hFF;
                tick();
            end
            itxControlComms = 8'h00;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_fire_controller.md
TX_FIRE_CONTROLLER -- requirements
Module: tx_fire_controller

Interface
REQ-001 SHALL provide parameter N_CH, default 4, number of transducer channels.
REQ-002 SHALL provide parameter CT_W, default 9, per-channel charge-time width in cycles.
REQ-003 SHALL provide parameter DLY_W, default 14, per-channel fire-delay width in prescaled ticks.
REQ-004 SHALL provide parameter DLY_DIV, default 1, delay prescale; one tick = 2^DLY_DIV cycles.
REQ-005 SHALL provide parameter PER_W, default 16, pulse-period width in cycles.
REQ-006 SHALL provide parameter ACK_TO, default 1023, ADC-ack timeout in cycles.
REQ-007 SHALL have port txCLK  in  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have port txRSTn  in  1  reset; asynchronous, active-low.
REQ-009 SHALL have port itxControlComms  in  8  command: 0x00 IDLE, 0x01 FIRE, all other values treated as IDLE.
REQ-010 SHALL have port iChargeTime  in  N_CH*CT_W  packed charge times; channel c at [c*CT_W +: CT_W].
REQ-011 SHALL have port iFireDelay  in  N_CH*DLY_W  packed fire delays; channel c at [c*DLY_W +: DLY_W].
REQ-012 SHALL have port iChanEnable  in  N_CH  per-channel enable mask.
REQ-013 SHALL have port iPulseCount  in  8  pulses per channel per shot; 0 treated as 1.
REQ-014 SHALL have port iPulsePeriod  in  PER_W  rising-edge-to-rising-edge pulse spacing in cycles.
REQ-015 SHALL have port itxADCTriggerAck  in  1  ADC acknowledge.
REQ-016 SHALL have port otxADCTriggerLine  out  1  ADC trigger request.
REQ-017 SHALL have port otxTransducerOutput  out  N_CH  transducer drive, one bit per channel.
REQ-018 SHALL have port otxBusy  out  1  high while a shot is in progress.
REQ-019 SHALL have port otxDone  out  1  high while a shot is complete and FIRE is still held.
REQ-020 SHALL have port otxAckTimeout  out  1  sticky flag: ADC ack not received within ACK_TO cycles.

Function
REQ-021 SHALL implement top FSM IDLE -> RUN -> DONE -> IDLE.
REQ-022 IDLE, comms==FIRE sampled at edge N: latch all config inputs, assert otxADCTriggerLine, set otxBusy, enter RUN; config changes after edge N have no effect on the shot.
REQ-023 RUN: each channel runs its own FSM WAIT -> HIGH -> LOW -> (WAIT for next pulse | FIN).
REQ-024 A channel that is disabled, or has charge time 0, SHALL enter FIN at edge N and never drive high.
REQ-025 Channel c first rising edge SHALL be at edge N+1+D_c*2^DLY_DIV, where D_c is the latched delay; delay counter width DLY_W+DLY_DIV, no wrap.
REQ-026 Each pulse SHALL be high for exactly CT_c cycles; CT_c all-ones is legal.
REQ-027 Successive rising edges SHALL be max(iPulsePeriod, CT_c+1) cycles apart; a channel SHALL emit exactly P pulses (P = latched count, 0 -> 1), then enter FIN with its output low.
REQ-028 When all channels are in FIN and the ADC handshake has resolved, the top FSM SHALL enter DONE on the next edge: otxBusy=0, otxDone=1.
REQ-029 ADC handshake: line high from edge N; first cycle ack is sampled high, line drops at that edge; ack asserted at or before edge N has no effect.
REQ-030 If ack is not received by ACK_TO cycles after edge N, the line SHALL drop, otxAckTimeout SHALL set, and the handshake counts as resolved.
REQ-031 otxAckTimeout SHALL clear only on reset or on the next IDLE->RUN transition.
REQ-032 DONE SHALL hold while comms==FIRE; any non-FIRE command SHALL return to IDLE, and otxDone SHALL clear at that edge.
REQ-033 Abort: a non-FIRE command in RUN SHALL, at that edge, drive all outputs low except otxAckTimeout, clear all counters, and enter IDLE.
REQ-034 A new shot SHALL require passing through IDLE; FIRE held continuously SHALL never re-fire.
REQ-035 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-036 txRSTn low SHALL immediately force: otxTransducerOutput=0, otxADCTriggerLine=0, otxBusy=0, otxDone=0, otxAckTimeout=0, all FSMs IDLE, all counters 0.
REQ-037 Reset deasserted mid-shot SHALL leave the block in IDLE; no shot resumes until FIRE is sampled from IDLE.

Verification
REQ-038 Defaults, all channels enabled, D=0, CT=5, P=1, FIRE at edge N, ack at N+3 -> each channel high on edges N+1..N+5; trigger line high N..N+2, low from N+3; otxDone=1 at N+7.
REQ-039 D={0,1,2,3}, CT=4, DLY_DIV=1 -> channel rises at N+1, N+3, N+5, N+7 respectively, each high 4 cycles.
REQ-040 CT=3, P=3, period=10 -> rises at N+1, N+11, N+21; period=2 with CT=3 -> rises 4 cycles apart.
REQ-041 Ack never asserted, ACK_TO=1023 -> line drops and otxAckTimeout=1 at edge N+1023; DONE reached afterwards.
REQ-042 Comms to 0x00 mid-pulse, or txRSTn pulsed low mid-pulse -> all drive outputs 0 at that edge (async for reset); a later FIRE starts a fresh shot from N.
REQ-043 Enable mask 0b0101 and CT_2=0 -> only channel 0 pulses; iChargeTime changed at N+2 -> pulse widths unchanged.
